// File: rtl/sort_frame_collector_if.sv
// Bundles the element input stream and the frame output toward the sorter.
// slave is the collector side; master is the feeder/consumer side.
interface sort_frame_collector_if #(
   parameter int DIM   = 4,
   parameter int WIDTH = 8,
   parameter int LW    = $clog2(DIM + 1)
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_data;
   logic                 in_last;
   logic [DIM*WIDTH-1:0] prand;
   logic                 frame_valid;
   logic                 frame_ready;
   logic [LW-1:0]        frame_len;

   modport slave (
      input  in_valid, in_data, in_last, frame_ready,
      output in_ready, prand, frame_valid, frame_len
   );

   modport master (
      output in_valid, in_data, in_last, frame_ready,
      input  in_ready, prand, frame_valid, frame_len
   );
endinterface

// File: rtl/sort_frame_collector.sv
// Collects serial elements into DIM-element frames for the bubble sorter.
// Double-buffered: a fill buffer assembles the next frame while the hold buffer drives prand.
module sort_frame_collector #(
   parameter int DIM   = 4,
   parameter int WIDTH = 8,
   parameter int LW    = $clog2(DIM + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   sort_frame_collector_if.slave bus
);

   typedef enum logic {FILLING, COMPLETE} fill_state_t;
   typedef enum logic {EMPTY, FULL}       hold_state_t;

   fill_state_t          fill_state_reg, fill_state_next;
   hold_state_t          hold_state_reg, hold_state_next;
   logic [LW-1:0]        count_reg, count_next;
   logic [LW-1:0]        fill_len_reg, fill_len_next;
   logic [LW-1:0]        frame_len_reg;
   logic [DIM*WIDTH-1:0] prand_reg;
   logic [DIM*WIDTH-1:0] fill_packed;
   logic                 alive_reg;
   logic                 frame_valid;
   logic                 hold_free;
   logic                 transfer;
   logic                 in_ready;
   logic                 accept;
   logic                 close;
   logic [LW-1:0]        base;

   assign frame_valid = (hold_state_reg == FULL);
   assign hold_free   = frame_valid & bus.frame_ready;
   assign transfer    = (fill_state_reg == COMPLETE) & ((hold_state_reg == EMPTY) | hold_free);
   // alive_reg keeps in_ready low until the first edge after reset release
   assign in_ready    = alive_reg & ((fill_state_reg == FILLING) | hold_free);
   assign accept      = bus.in_valid & in_ready;
   // A completed frame leaves on this same edge, so the new element starts at slot 0
   assign base        = (fill_state_reg == COMPLETE) ? '0 : count_reg;
   assign close       = accept & (bus.in_last | (base == LW'(DIM - 1)));

   always_comb begin
      fill_state_next = fill_state_reg;
      hold_state_next = hold_state_reg;
      count_next      = count_reg;
      fill_len_next   = fill_len_reg;
      if (transfer) begin
         fill_state_next = FILLING;
         count_next      = '0;
         hold_state_next = FULL;
      end else if (hold_free) begin
         hold_state_next = EMPTY;
      end
      if (accept) begin
         if (close) begin
            fill_state_next = COMPLETE;
            fill_len_next   = base + LW'(1);
            count_next      = '0;
         end else begin
            fill_state_next = FILLING;
            count_next      = base + LW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_state_reg <= FILLING;
         hold_state_reg <= EMPTY;
         count_reg      <= '0;
         fill_len_reg   <= '0;
         frame_len_reg  <= '0;
         prand_reg      <= '0;
         alive_reg      <= 1'b0;
      end else begin
         fill_state_reg <= fill_state_next;
         hold_state_reg <= hold_state_next;
         count_reg      <= count_next;
         fill_len_reg   <= fill_len_next;
         alive_reg      <= 1'b1;
         if (transfer) begin
            prand_reg     <= fill_packed;
            frame_len_reg <= fill_len_reg;
         end
      end
   end

   // Slots above the closing element are padded with all-ones so they sort to the top
   for (genvar gi = 0; gi < DIM; gi++) begin : g_slot
      logic [WIDTH-1:0] slot_reg;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            slot_reg <= '0;
         end else if (accept) begin
            if (base == LW'(gi))
               slot_reg <= bus.in_data;
            else if (close && (LW'(gi) > base))
               slot_reg <= '1;
         end
      end

      assign fill_packed[WIDTH*gi +: WIDTH] = slot_reg;
   end

   assign bus.in_ready    = in_ready;
   assign bus.prand       = prand_reg;
   assign bus.frame_valid = frame_valid;
   assign bus.frame_len   = frame_len_reg;

endmodule

// File: tb/tb_sort_frame_collector.sv
// Directed and randomized-gap checks of sort_frame_collector with a frame scoreboard.
module tb_sort_frame_collector;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   sort_frame_collector_if #(.DIM(4), .WIDTH(8)) bus();

   sort_frame_collector #(.DIM(4), .WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] p;
      logic [2:0]  l;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   bit   rand_done;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] p, input logic [2:0] l);
      exp_t e;
      e.p = p;
      e.l = l;
      exp_q.push_back(e);
   endtask

   task automatic send(input logic [7:0] d, input bit last);
      bit rdy;
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      do begin
         @(negedge clk);
         rdy = bus.in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!rdy && n < 200);
      if (!rdy) chk("send_timeout", 32'd0, 32'd1);
      $display("sent data=%h last=%0d", d, last);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus.frame_ready = 1'b1;
      while (exp_q.size() > 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain_empty", exp_q.size(), 0);
   endtask

   // Frame monitor: pops on every consumed frame and checks hold stability
   task automatic monitor();
      logic [31:0] prev_p;
      logic [2:0]  prev_l;
      bit          prev_hold;
      exp_t        e;
      prev_hold = 1'b0;
      prev_p = '0;
      prev_l = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_hold = 1'b0;
         end else begin
            if (prev_hold) begin
               chk("hold_valid", {31'd0, bus.frame_valid}, 32'd1);
               chk("hold_prand", bus.prand, prev_p);
               chk("hold_len", {29'd0, bus.frame_len}, {29'd0, prev_l});
            end
            if (bus.frame_valid && bus.frame_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_frame", bus.prand, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  $display("frame prand=%h len=%0d exp=%h/%0d", bus.prand, bus.frame_len, e.p, e.l);
                  chk("frame_prand", bus.prand, e.p);
                  chk("frame_len", {29'd0, bus.frame_len}, {29'd0, e.l});
               end
            end
            prev_hold = bus.frame_valid & ~bus.frame_ready;
            prev_p    = bus.prand;
            prev_l    = bus.frame_len;
         end
      end
   endtask

   task automatic stimulus();
      logic [7:0]  el [4];
      logic [31:0] p;
      int          len;
      bit          last;

      bus.in_valid    = 1'b0;
      bus.in_data     = '0;
      bus.in_last     = 1'b0;
      bus.frame_ready = 1'b0;

      // Reset state
      #3;
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("rst_valid", {31'd0, bus.frame_valid}, 32'd0);
      chk("rst_prand", bus.prand, 32'd0);
      chk("rst_len", {29'd0, bus.frame_len}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("pre_edge_in_ready", {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk);
      #1;
      chk("post_edge_in_ready", {31'd0, bus.in_ready}, 32'd1);

      // Full frame, latency check
      bus.frame_ready = 1'b1;
      push(32'h20401030, 3'd4);
      send(8'h30, 0); send(8'h10, 0); send(8'h40, 0); send(8'h20, 0);
      @(negedge clk);
      chk("lat_not_yet", {31'd0, bus.frame_valid}, 32'd0);
      @(negedge clk);
      chk("lat_valid", {31'd0, bus.frame_valid}, 32'd1);
      @(posedge clk); #1;

      // Short frame, then all-ones data, then in_last on 4th, then length 1
      push(32'hFFFF0705, 3'd2);
      send(8'h05, 0); send(8'h07, 1);
      push(32'hFFFFFFFF, 3'd2);
      send(8'hFF, 0); send(8'hFF, 1);
      push(32'h64636261, 3'd4);
      send(8'h61, 0); send(8'h62, 0); send(8'h63, 0); send(8'h64, 1);
      push(32'hFFFFFF9A, 3'd1);
      send(8'h9A, 1);
      drain();

      // Back-to-back frames with downstream stalled
      bus.frame_ready = 1'b0;
      push(32'h04030201, 3'd4);
      push(32'h14131211, 3'd4);
      push(32'h24232221, 3'd4);
      send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
      send(8'h11, 0); send(8'h12, 0); send(8'h13, 0); send(8'h14, 0);
      @(negedge clk);
      chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("stall_prand", bus.prand, 32'h04030201);
      @(posedge clk); #1;
      bus.frame_ready = 1'b1;
      bus.in_valid    = 1'b1;
      bus.in_data     = 8'h21;
      @(negedge clk);
      chk("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk); #1;
      bus.frame_ready = 1'b0;
      bus.in_valid    = 1'b0;
      @(negedge clk);
      chk("second_loaded", bus.prand, 32'h14131211);
      @(posedge clk); #1;
      send(8'h22, 0); send(8'h23, 0); send(8'h24, 0);
      drain();

      // Reset with a held frame and a partial fill
      bus.frame_ready = 1'b0;
      send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 0); send(8'hA4, 0);
      send(8'hB1, 0); send(8'hB2, 0);
      chk("pre_rst_valid", {31'd0, bus.frame_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", {31'd0, bus.frame_valid}, 32'd0);
      chk("midrst_prand", bus.prand, 32'd0);
      chk("midrst_len", {29'd0, bus.frame_len}, 32'd0);
      chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("rel_valid", {31'd0, bus.frame_valid}, 32'd0);
      bus.frame_ready = 1'b1;
      push(32'h54535251, 3'd4);
      send(8'h51, 0); send(8'h52, 0); send(8'h53, 0); send(8'h54, 0);
      drain();

      // Random gaps on both sides
      rand_done = 1'b0;
      fork
         begin
            for (int f = 0; f < 1000; f++) begin
               len  = $urandom_range(1, 4);
               last = (len < 4) ? 1'b1 : 1'($urandom % 2);
               p    = 32'hFFFFFFFF;
               for (int k = 0; k < len; k++) begin
                  el[k] = ($urandom % 4 == 0) ? 8'hFF : 8'($urandom);
                  p[8*k +: 8] = el[k];
               end
               push(p, 3'(len));
               for (int k = 0; k < len; k++) begin
                  if ($urandom % 3 == 0) begin
                     @(posedge clk); #1;
                  end
                  send(el[k], (k == len - 1) ? last : 1'b0);
               end
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk); #1;
               bus.frame_ready = ($urandom % 3 != 0);
            end
         end
      join
      drain();
   endtask

   initial begin
      fork
         monitor();
         begin
            stimulus();
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
         end
      join_any
   end
endmodule

// File: doc/sort_frame_collector.md
Name: sort_frame_collector

Overview:
- Upstream feeder for the combinational bubble sorter.
- Accepts a serial stream of WIDTH-bit elements over a valid/ready handshake and assembles each frame of DIM elements into the packed vector the sorter consumes.
- Double-buffered: the next frame fills while the current one is held stable on the sorter input.
- Short frames, closed early by in_last, are padded with all-ones so the padding sinks to the top indices after an ascending sort.

Parameters:
- DIM, 4, elements per frame (>=2).
- WIDTH, 8, bits per element.
- LW, $clog2(DIM+1), width of frame_len.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  element on in_data is valid.
- in_ready  output  1  collector can accept an element this cycle.
- in_data  input  WIDTH  element value.
- in_last  input  1  element closes the current frame.
- prand  output  DIM*WIDTH  packed frame to sorter; element i at bits [WIDTH*(i+1)-1 : WIDTH*i]; element 0 is the first received.
- frame_valid  output  1  prand and frame_len hold a complete frame.
- frame_ready  input  1  downstream consumes the frame this cycle.
- frame_len  output  LW  number of real (non-pad) elements in the held frame, 1..DIM.

Behaviour:
- Reset (async, rst_n=0):
  - fill buffer cleared; fill count = 0.
  - hold buffer empty.
  - prand = 0, frame_valid = 0, frame_len = 0, in_ready = 0 while rst_n=0.
  - in_ready = 1 from the first edge after deassertion.
- Accept: an element is taken on an edge where in_valid & in_ready; it is written to fill slot [count], and count increments.
- Frame close: the accepted element closes the frame if in_last=1 or count==DIM-1, whichever comes first.
- Padding: on close, slots count+1..DIM-1 are written as {WIDTH{1'b1}}. Recorded length = count+1.
- Fill FSM: FILLING -> COMPLETE on close.
  - COMPLETE -> FILLING (count=0) when the frame transfers to hold.
  - While COMPLETE, in_ready=0.
- Hold FSM: EMPTY/FULL.
  - Transfer fill->hold on an edge where fill is COMPLETE and (hold EMPTY or frame_valid & frame_ready).
  - prand/frame_len load and frame_valid=1 on that edge.
  - frame_valid & frame_ready without a pending transfer -> hold EMPTY, frame_valid=0. prand keeps its last value, but is don't-care when frame_valid=0.
- Latency: the closing element is accepted at edge t; frame_valid=1 after edge t+1 if hold was free.
- Throughput: one element per cycle sustained while downstream accepts each frame within the one-cycle COMPLETE window.
- in_ready is combinational: 1 when fill is FILLING, or when hold will free this cycle (frame_valid & frame_ready).
  - The frame then transfers on that edge and the new element enters slot 0 of a fresh fill.
  - No element is ever dropped or overwritten.
- Stability: prand and frame_len are stable while frame_valid=1 and frame_ready=0. The combinational sorter must see no change mid-hold.
- in_last on the DIM-th element: normal close, no padding.
- in_last ignored when in_valid=0 or in_ready=0.
- Frame of length 1 (in_last on the first element): slots 1..DIM-1 padded, frame_len=1.
- Reset mid-frame: partial fill and held frame are discarded; no frame_valid after release until a new frame completes.
- Elements equal to all-ones are legal. frame_len distinguishes them from padding.

Test Plan:
- DIM=4, WIDTH=8: send 0x30,0x10,0x40,0x20 back-to-back, frame_ready=1 -> frame_valid 1 cycle after 4th accept; prand=0x20401030, frame_len=4.
- Send 0x05, 0x07 with in_last on 0x07 -> prand=0xFFFF0705, frame_len=2; the next frame starts at slot 0.
- Two full frames back-to-back with frame_ready=0 -> first held stable.
  - Second completes; in_ready drops to 0 after its 4th accept.
  - Raise frame_ready for 1 cycle -> second frame loads, in_ready=1 the same cycle, no element lost.
- Single element 0x9A with in_last -> prand=0xFFFFFF9A, frame_len=1.
- Pull rst_n low after 2 of 4 elements and after a frame is held -> frame_valid, prand, frame_len go to 0 immediately.
  - After release, send 4 new elements -> only the new frame appears.
- Random in_valid/frame_ready gaps over 1000 frames with a scoreboard -> every accepted element appears exactly once in order; prand is unchanged while frame_valid & !frame_ready.
